// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer: issues one load/store at a time on the valid/ready bus,
// holds the pipeline while it is in flight, and reports load data / fault to the memory stage.
module dmem_access_ctrl #(
    parameter int ADDR_W  = 64,
    parameter int DATA_W  = 64,
    parameter int TIMEOUT = 255
) (
    input  logic                  cpu_clk_50M,
    input  logic                  cpu_rst_n,
    input  logic                  mem_req,
    input  logic                  mem_we,
    input  logic [1:0]            mem_size,
    input  logic [ADDR_W-1:0]     mem_addr,
    input  logic [DATA_W-1:0]     mem_wdata,
    input  logic [DATA_W/8-1:0]   mem_wstrb,
    input  logic                  excep_flush,
    output logic                  bus_req_valid,
    input  logic                  bus_req_ready,
    output logic                  bus_we,
    output logic [ADDR_W-1:0]     bus_addr,
    output logic [DATA_W-1:0]     bus_wdata,
    output logic [DATA_W/8-1:0]   bus_wstrb,
    input  logic                  bus_rsp_valid,
    input  logic [DATA_W-1:0]     bus_rsp_data,
    input  logic                  bus_rsp_err,
    output logic                  data_read_stall,
    output logic [DATA_W-1:0]     mem_rdata,
    output logic                  mem_done,
    output logic                  mem_fault
);

    localparam int STRB_W = DATA_W / 8;
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE,
        S_DRAIN
    } state_t;

    state_t              state_reg, state_next;
    logic                we_reg, we_next;
    logic [ADDR_W-1:0]   addr_reg, addr_next;
    logic [DATA_W-1:0]   wdata_reg, wdata_next;
    logic [STRB_W-1:0]   wstrb_reg, wstrb_next;
    logic [DATA_W-1:0]   rdata_reg, rdata_next;
    logic                fault_reg, fault_next;
    logic                abort_reg, abort_next;
    logic                done_pend_reg, done_pend_next;
    logic                outst_reg, outst_next;
    logic [7:0]          cnt_reg, cnt_next;

    // Low address bits that must be zero for each access size (byte/half/word/dword).
    logic [2:0] align_mask;
    logic       misaligned;

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_align
            assign align_mask[gi] = (mem_size > 2'(gi));
        end
    endgenerate

    assign misaligned = |(mem_addr[2:0] & align_mask);

    always_ff @(posedge cpu_clk_50M or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state_reg     <= S_IDLE;
            we_reg        <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
            wstrb_reg     <= '0;
            rdata_reg     <= '0;
            fault_reg     <= 1'b0;
            abort_reg     <= 1'b0;
            done_pend_reg <= 1'b0;
            outst_reg     <= 1'b0;
            cnt_reg       <= '0;
        end else begin
            state_reg     <= state_next;
            we_reg        <= we_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
            wstrb_reg     <= wstrb_next;
            rdata_reg     <= rdata_next;
            fault_reg     <= fault_next;
            abort_reg     <= abort_next;
            done_pend_reg <= done_pend_next;
            outst_reg     <= outst_next;
            cnt_reg       <= cnt_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        we_next         = we_reg;
        addr_next       = addr_reg;
        wdata_next      = wdata_reg;
        wstrb_next      = wstrb_reg;
        rdata_next      = rdata_reg;
        fault_next      = fault_reg;
        abort_next      = abort_reg;
        done_pend_next  = done_pend_reg;
        outst_next      = outst_reg;
        cnt_next        = cnt_reg;
        bus_req_valid   = 1'b0;
        data_read_stall = 1'b0;
        mem_done        = 1'b0;

        case (state_reg)
            S_IDLE: begin
                data_read_stall = mem_req & ~excep_flush;
                if (mem_req && !excep_flush) begin
                    we_next        = mem_we;
                    addr_next      = mem_addr;
                    wdata_next     = mem_wdata;
                    wstrb_next     = mem_wstrb;
                    abort_next     = 1'b0;
                    done_pend_next = 1'b0;
                    outst_next     = 1'b0;
                    fault_next     = misaligned;
                    state_next     = misaligned ? S_DONE : S_REQ;
                end
            end

            S_REQ: begin
                // The request stays up until accepted even when aborted, so the bus never sees a withdrawal.
                bus_req_valid   = 1'b1;
                data_read_stall = 1'b1;
                if (excep_flush) begin
                    abort_next = 1'b1;
                end
                if (bus_req_ready) begin
                    cnt_next   = '0;
                    outst_next = 1'b1;
                    state_next = (excep_flush || abort_reg) ? S_DRAIN : S_WAIT;
                end
            end

            S_WAIT: begin
                data_read_stall = 1'b1;
                cnt_next        = cnt_reg + 8'd1;
                if (excep_flush) begin
                    abort_next = 1'b1;
                    if (bus_rsp_valid) begin
                        outst_next = 1'b0;
                        state_next = S_IDLE;
                    end else begin
                        state_next = S_DRAIN;
                    end
                end else if (bus_rsp_valid) begin
                    outst_next = 1'b0;
                    fault_next = bus_rsp_err;
                    if (!we_reg) begin
                        rdata_next = bus_rsp_data;
                    end
                    state_next = S_DONE;
                end else if (cnt_reg == TO_LAST) begin
                    fault_next     = 1'b1;
                    done_pend_next = 1'b1;
                    state_next     = S_DRAIN;
                end
            end

            S_DONE: begin
                mem_done = 1'b1;
                if (bus_rsp_valid) begin
                    outst_next = 1'b0;
                end
                // A timed-out access still owes the bus one response; go back and absorb it.
                state_next = (outst_reg && !bus_rsp_valid) ? S_DRAIN : S_IDLE;
            end

            S_DRAIN: begin
                data_read_stall = mem_req;
                if (excep_flush) begin
                    abort_next = 1'b1;
                end
                if (bus_rsp_valid) begin
                    outst_next = 1'b0;
                end
                if (done_pend_reg && !abort_reg && !excep_flush) begin
                    done_pend_next = 1'b0;
                    state_next     = S_DONE;
                end else if (bus_rsp_valid || !outst_reg) begin
                    done_pend_next = 1'b0;
                    state_next     = S_IDLE;
                end
            end

            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    assign bus_we    = we_reg;
    assign bus_addr  = addr_reg;
    assign bus_wdata = wdata_reg;
    assign bus_wstrb = wstrb_reg;
    assign mem_rdata = rdata_reg;
    assign mem_fault = mem_done & fault_reg;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Bench for dmem_access_ctrl: cycle-driven stimulus plays the memory stage and the bus,
// expected completions go into a scoreboard that a negedge monitor drains.
module tb_dmem_access_ctrl;

    localparam int ADDR_W  = 64;
    localparam int DATA_W  = 64;
    localparam int TIMEOUT = 255;
    localparam int MAXC    = 400;

    logic                cpu_clk_50M = 1'b0;
    logic                cpu_rst_n   = 1'b0;
    logic                mem_req     = 1'b0;
    logic                mem_we      = 1'b0;
    logic [1:0]          mem_size    = '0;
    logic [ADDR_W-1:0]   mem_addr    = '0;
    logic [DATA_W-1:0]   mem_wdata   = '0;
    logic [DATA_W/8-1:0] mem_wstrb   = '0;
    logic                excep_flush = 1'b0;
    logic                bus_req_valid;
    logic                bus_req_ready = 1'b0;
    logic                bus_we;
    logic [ADDR_W-1:0]   bus_addr;
    logic [DATA_W-1:0]   bus_wdata;
    logic [DATA_W/8-1:0] bus_wstrb;
    logic                bus_rsp_valid = 1'b0;
    logic [DATA_W-1:0]   bus_rsp_data  = '0;
    logic                bus_rsp_err   = 1'b0;
    logic                data_read_stall;
    logic [DATA_W-1:0]   mem_rdata;
    logic                mem_done;
    logic                mem_fault;

    dmem_access_ctrl #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .cpu_clk_50M    (cpu_clk_50M),
        .cpu_rst_n      (cpu_rst_n),
        .mem_req        (mem_req),
        .mem_we         (mem_we),
        .mem_size       (mem_size),
        .mem_addr       (mem_addr),
        .mem_wdata      (mem_wdata),
        .mem_wstrb      (mem_wstrb),
        .excep_flush    (excep_flush),
        .bus_req_valid  (bus_req_valid),
        .bus_req_ready  (bus_req_ready),
        .bus_we         (bus_we),
        .bus_addr       (bus_addr),
        .bus_wdata      (bus_wdata),
        .bus_wstrb      (bus_wstrb),
        .bus_rsp_valid  (bus_rsp_valid),
        .bus_rsp_data   (bus_rsp_data),
        .bus_rsp_err    (bus_rsp_err),
        .data_read_stall(data_read_stall),
        .mem_rdata      (mem_rdata),
        .mem_done       (mem_done),
        .mem_fault      (mem_fault)
    );

    always #10 cpu_clk_50M = ~cpu_clk_50M;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          txn_id   = 0;
    logic [63:0] last_rdata = '0;
    logic        exp_fault_q[$];
    logic [63:0] exp_rdata_q[$];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: actual=%h required=%h", name, act, exp);
    endtask

    task automatic step();
        @(posedge cpu_clk_50M);
        #1;
        bus_req_ready = 1'b0;
        bus_rsp_valid = 1'b0;
        bus_rsp_err   = 1'b0;
        excep_flush   = 1'b0;
    endtask

    // Scoreboard side: every completion pulse must match the oldest predicted result.
    always @(negedge cpu_clk_50M) begin : monitor
        if (cpu_rst_n && mem_done) begin
            if (exp_fault_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_done: actual=mem_done with fault=%0b required=no completion", mem_fault);
            end else begin
                chk("done_fault", mem_fault, exp_fault_q.pop_front());
                chk("done_rdata", mem_rdata, exp_rdata_q.pop_front());
            end
        end
    end

    task automatic run_txn(input logic we, input logic [1:0] size, input logic [63:0] addr,
                           input logic [63:0] wdata, input logic [7:0] wstrb,
                           input int ready_dly, input int rsp_dly, input logic err,
                           input logic [63:0] rdata, input int flush_at, input bit flush_req,
                           input bit tmo, input bit flush_idle, input bit probe);
        bit mis, aborted, accepted, finished;
        int since, req_cycles;
        mis     = (addr % (64'd1 << size)) != 64'd0;
        aborted = !mis && (flush_at != 0 || flush_req);
        txn_id++;
        if (mis) begin
            exp_fault_q.push_back(1'b1);
            exp_rdata_q.push_back(last_rdata);
        end else if (!aborted) begin
            if (tmo) begin
                exp_fault_q.push_back(1'b1);
            end else begin
                if (!we) last_rdata = rdata;
                exp_fault_q.push_back(err);
            end
            exp_rdata_q.push_back(last_rdata);
        end
        $display("txn %0d: we=%0b size=%0d addr=%h mis=%0b abort=%0b timeout=%0b err=%0b rsp=%h",
                 txn_id, we, size, addr, mis, aborted, tmo, err, rdata);

        if (flush_idle) begin
            step();
            mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr;
            mem_wdata = wdata; mem_wstrb = wstrb; excep_flush = 1'b1;
            #1;
            chk("stall_flush_idle", data_read_stall, 0);
            chk("no_req_flush_idle", bus_req_valid, 0);
        end
        step();
        mem_req = 1'b1; mem_we = we; mem_size = size; mem_addr = addr;
        mem_wdata = wdata; mem_wstrb = wstrb;
        #1;
        chk("stall_on_request", data_read_stall, 1);

        accepted = 0; finished = 0; since = 0; req_cycles = 0;
        for (int c = 0; c < MAXC && !finished; c++) begin
            step();
            #1;
            if (accepted) since++;
            if (mis) begin
                chk("misalign_no_req", bus_req_valid, 0);
                chk("misalign_done", mem_done, 1);
                chk("stall_in_done", data_read_stall, 0);
                finished = 1;
            end else if (!accepted) begin
                chk("req_valid_held", bus_req_valid, 1);
                chk("stall_in_req", data_read_stall, 1);
                if (flush_req && req_cycles == 0) excep_flush = 1'b1;
                if (req_cycles == ready_dly) begin
                    bus_req_ready = 1'b1;
                    accepted = 1;
                    chk("bus_we", bus_we, we);
                    chk("bus_addr", bus_addr, addr);
                    chk("bus_wdata", bus_wdata, wdata);
                    chk("bus_wstrb", bus_wstrb, wstrb);
                end
                req_cycles++;
            end else if (tmo) begin
                if (mem_done) begin
                    chk("timeout_latency", since >= TIMEOUT + 1 && since <= TIMEOUT + 3, 1);
                    chk("stall_in_done", data_read_stall, 0);
                    finished = 1;
                end else if (since == TIMEOUT) begin
                    chk("stall_in_wait", data_read_stall, 1);
                end
            end else begin
                chk("no_req_after_accept", bus_req_valid, 0);
                if (since == flush_at) excep_flush = 1'b1;
                if (since == rsp_dly) begin
                    bus_rsp_valid = 1'b1;
                    bus_rsp_data  = rdata;
                    bus_rsp_err   = err;
                end
                if (aborted) begin
                    chk("no_done_aborted", mem_done, 0);
                    chk("stall_pending", data_read_stall, 1);
                    if (since == rsp_dly) finished = 1;
                end else if (since == rsp_dly + 1) begin
                    chk("done_latency", mem_done, 1);
                    chk("stall_in_done", data_read_stall, 0);
                    finished = 1;
                end else begin
                    chk("no_early_done", mem_done, 0);
                    chk("stall_pending", data_read_stall, 1);
                end
            end
        end
        if (!finished) begin
            n_checks++;
            $display("FAIL txn_bound: actual=no completion after %0d cycles required=completion", MAXC);
        end else if (tmo) begin
            // Next instruction waits while the late response is absorbed.
            for (int k = 1; k <= 10; k++) begin
                step();
                mem_req = 1'b1; mem_addr = addr + 64'h40;
                #1;
                chk("drain_holds_stall", data_read_stall, 1);
                chk("drain_no_req", bus_req_valid, 0);
                chk("no_second_done", mem_done, 0);
                if (k == 10) begin
                    bus_rsp_valid = 1'b1;
                    bus_rsp_data  = 64'hbad0_bad0_bad0_bad0;
                end
            end
        end
        if (probe || tmo) begin
            // In IDLE a flushed request is not stalled; DRAIN would still stall it.
            step();
            mem_req = 1'b1; excep_flush = 1'b1;
            #1;
            chk("idle_probe_stall", data_read_stall, 0);
            chk("idle_probe_done", mem_done, 0);
            chk("idle_probe_req", bus_req_valid, 0);
        end
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: actual=simulation still running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic        we, err, fi, fr, pr;
        logic [1:0]  sz;
        logic [63:0] addr, wd, rd;
        int          rdy, rsp, fa, mode, gap;

        #5;
        chk("rst_req_valid", bus_req_valid, 0);
        chk("rst_bus_we", bus_we, 0);
        chk("rst_bus_addr", bus_addr, 0);
        chk("rst_bus_wdata", bus_wdata, 0);
        chk("rst_bus_wstrb", bus_wstrb, 0);
        chk("rst_stall", data_read_stall, 0);
        chk("rst_rdata", mem_rdata, 0);
        chk("rst_done", mem_done, 0);
        chk("rst_fault", mem_fault, 0);
        @(posedge cpu_clk_50M);
        #5 cpu_rst_n = 1'b1;

        // Directed cases
        run_txn(0, 2'd3, 64'h8000_1000, 64'h0, 8'hff, 1, 3, 0, 64'h1122_3344_5566_7788, 0, 0, 0, 0, 1);
        run_txn(1, 2'd1, 64'h8000_0003, 64'h0000_0000_abcd_0000, 8'h0c, 0, 1, 0, 64'h0, 0, 0, 0, 0, 1);
        run_txn(0, 2'd3, 64'h8000_1008, 64'h0, 8'hff, 0, 3, 0, 64'h5555_6666_7777_8888, 1, 0, 0, 0, 1);
        run_txn(0, 2'd2, 64'h8000_1010, 64'h0, 8'h0f, 0, 1, 0, 64'h0, 0, 0, 1, 0, 1);
        run_txn(0, 2'd3, 64'h8000_1018, 64'h0, 8'hff, 0, 2, 1, 64'h0f0f_0f0f_0f0f_0f0f, 0, 0, 0, 0, 0);
        run_txn(0, 2'd2, 64'h8000_1020, 64'h0, 8'h0f, 0, 1, 0, 64'h0000_0000_1234_5678, 0, 0, 0, 0, 1);
        run_txn(1, 2'd3, 64'h8000_1028, 64'h9999_aaaa_bbbb_cccc, 8'hff, 2, 2, 0, 64'h0, 2, 0, 0, 0, 1);
        run_txn(0, 2'd0, 64'h8000_1031, 64'h0, 8'h02, 2, 1, 0, 64'h77, 0, 1, 0, 1, 1);

        // Randomized traffic
        for (int t = 0; t < 40; t++) begin
            we   = 1'($urandom_range(0, 1));
            sz   = 2'($urandom_range(0, 3));
            addr = 64'h8000_0000 + 64'($urandom_range(0, 4095));
            wd   = {32'($urandom), 32'($urandom)};
            rd   = {32'($urandom), 32'($urandom)};
            rdy  = $urandom_range(0, 3);
            rsp  = $urandom_range(1, 6);
            err  = ($urandom_range(0, 5) == 0);
            mode = $urandom_range(0, 9);
            fa   = (mode < 2) ? $urandom_range(1, rsp) : 0;
            fr   = (mode == 2);
            fi   = ($urandom_range(0, 7) == 0);
            pr   = 1'($urandom_range(0, 1));
            run_txn(we, sz, addr, wd, 8'($urandom), rdy, rsp, err, rd, fa, fr, 0, fi, pr);
            gap = $urandom_range(0, 2);
            for (int g = 0; g < gap; g++) begin
                step();
                mem_req = 1'b0;
            end
        end

        // Asynchronous reset in the middle of a store's WAIT phase
        step();
        mem_req = 1'b1; mem_we = 1'b1; mem_size = 2'd3; mem_addr = 64'h8000_2000;
        mem_wdata = 64'hdead_beef_cafe_f00d; mem_wstrb = 8'hff;
        step();
        bus_req_ready = 1'b1;
        step();
        step();
        #5;
        cpu_rst_n = 1'b0;
        mem_req   = 1'b0;
        #1;
        chk("arst_req_valid", bus_req_valid, 0);
        chk("arst_bus_we", bus_we, 0);
        chk("arst_bus_addr", bus_addr, 0);
        chk("arst_bus_wdata", bus_wdata, 0);
        chk("arst_bus_wstrb", bus_wstrb, 0);
        chk("arst_stall", data_read_stall, 0);
        chk("arst_rdata", mem_rdata, 0);
        chk("arst_done", mem_done, 0);
        chk("arst_fault", mem_fault, 0);
        last_rdata = '0;
        @(posedge cpu_clk_50M);
        #5 cpu_rst_n = 1'b1;
        run_txn(1, 2'd1, 64'h8000_2002, 64'h0000_0000_1111_0000, 8'h0c, 1, 2, 0, 64'h0, 0, 0, 0, 0, 1);
        run_txn(0, 2'd3, 64'h8000_2008, 64'h0, 8'hff, 0, 1, 0, 64'h0123_4567_89ab_cdef, 0, 0, 0, 0, 1);

        step();
        mem_req = 1'b0;
        step();
        chk("scoreboard_empty", exp_fault_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/dmem_access_ctrl.md
Name: dmem_access_ctrl

Overview:
Sequences data-memory loads and stores from the memory stage onto the core's valid/ready data bus. It generates data_read_stall, which freezes the pipeline and makes the MEM/WB register insert a bubble. It returns load data and fault status to the memory stage. It aborts cleanly on excep_flush, drains any outstanding bus response, and bounds every access with a timeout.

Parameters:
ADDR_W, 64, address width
DATA_W, 64, data width; strobe width is DATA_W/8
TIMEOUT, 255, maximum cycles in WAIT before a fault (8-bit counter)

Ports:
cpu_clk_50M  in  1  clock
cpu_rst_n  in  1  asynchronous active-low reset
mem_req  in  1  memory stage holds a load/store
mem_we  in  1  1 = store, 0 = load
mem_size  in  2  0 = byte, 1 = half, 2 = word, 3 = dword
mem_addr  in  ADDR_W  byte address
mem_wdata  in  DATA_W  store data, already lane-aligned
mem_wstrb  in  DATA_W/8  byte strobes
excep_flush  in  1  exception/trap flush from the CSR unit
bus_req_valid  out  1  request valid
bus_req_ready  in  1  bus accepts request
bus_we  out  1  write enable
bus_addr  out  ADDR_W  latched address
bus_wdata  out  DATA_W  latched store data
bus_wstrb  out  DATA_W/8  latched strobes
bus_rsp_valid  in  1  response valid, one cycle per accepted request
bus_rsp_data  in  DATA_W  read data
bus_rsp_err  in  1  bus error
data_read_stall  out  1  STOP = 1: hold the pipeline
mem_rdata  out  DATA_W  captured load data
mem_done  out  1  one-cycle completion pulse
mem_fault  out  1  qualifies mem_done: misaligned, bus error or timeout

Behaviour:
- Reset (async, cpu_rst_n = 0):
  - state = IDLE.
  - All outputs are 0; bus_addr, bus_wdata, bus_wstrb and mem_rdata are 0.
  - Timeout counter is 0.
- States: IDLE, REQ, WAIT, DONE, DRAIN.
- IDLE:
  - If mem_req = 1 and excep_flush = 0: latch we/addr/wdata/wstrb/size.
  - Misalignment test: addr mod 2^size != 0.
    - Misaligned: go to DONE with fault = 1, no bus activity.
    - Aligned: go to REQ.
  - data_read_stall is combinational and equals mem_req & ~excep_flush in IDLE.
- REQ:
  - bus_req_valid = 1, driven from the latched fields. It is never withdrawn before bus_req_ready.
  - When bus_req_ready = 1: go to WAIT and clear the counter.
- WAIT:
  - The counter increments each cycle.
  - When bus_rsp_valid = 1: mem_rdata <= bus_rsp_data (loads only; stores leave mem_rdata unchanged), fault <= bus_rsp_err, go to DONE.
  - When the counter reaches TIMEOUT with no response: fault <= 1, go to DRAIN_TO (the DRAIN state with the done-pending flag set).
- DONE:
  - mem_done = 1 and mem_fault = fault for exactly this cycle.
  - data_read_stall = 0, so the stage advances at this clock edge.
  - Next state is IDLE. No new request is accepted in DONE.
- data_read_stall is 1 in REQ, WAIT and DRAIN, and 0 in DONE.
- Total latency from the accepted bus_req_ready edge to mem_done is 1 cycle after bus_rsp_valid.
- excep_flush:
  - In IDLE or DONE: no new transaction starts.
  - In REQ, WAIT or DRAIN: set the abort flag. The handshake continues, because bus_req_valid stays asserted until bus_req_ready. Then go to or stay in DRAIN.
  - An aborted access never produces mem_done, and mem_rdata is not updated.
- DRAIN:
  - Waits for the one outstanding bus_rsp_valid and discards it.
  - After a timeout the response is also waited for. The done-pending flag makes DONE fire with fault = 1 immediately on timeout while DRAIN still absorbs the late response.
  - Exits to IDLE, or to DONE if done-pending and not aborted.
  - data_read_stall = mem_req in DRAIN, so no new access is issued until the drain completes.
- Simultaneous events:
  - excep_flush and bus_rsp_valid in the same WAIT cycle: the response is discarded, go to IDLE, no mem_done.
  - excep_flush has priority over timeout.
- At most one outstanding bus transaction at any time.

Test Plan:
- Aligned dword load at 0x80001000, bus_req_ready on the 2nd REQ cycle, response 3 cycles later with data 0x1122334455667788 -> stall high from the request cycle through WAIT; 1 cycle after response: mem_done = 1, mem_fault = 0, mem_rdata = 0x1122334455667788, stall = 0.
- Store half to 0x80000003 -> no bus_req_valid; next cycle mem_done = 1, mem_fault = 1.
- Load; excep_flush asserted in WAIT; response arrives 2 cycles later -> no mem_done, mem_rdata unchanged, state IDLE after the response, a new mem_req is stalled until then.
- Load with the response withheld -> after TIMEOUT = 255 WAIT cycles: mem_done = 1 and mem_fault = 1. A late response 10 cycles later is absorbed with no second mem_done.
- Back-to-back loads with bus_rsp_err = 1 on the first -> first completes with mem_fault = 1; the second starts in IDLE on the cycle after DONE.
- cpu_rst_n pulsed low during WAIT -> all outputs 0 immediately (async), state IDLE.
